// File: rtl/mips_pkg.sv
// Shared widths and types for the MIPS register file slice.
package mips_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [DATA_W_DEF-1:0] word_t;
  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register with set (reserve) and clear (commit).
// Lookups see this cycle's clear but not this cycle's set.
module regfile_scoreboard
  import mips_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] lk_addr,
  output logic [NUM_RD-1:0]        lk_busy
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;

  // Set is applied after clear so a same-cycle reservation (newer producer) wins.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_addr] = 1'b0;
    if (set_en) busy_nxt[set_addr] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_lk
    logic [ADDR_W-1:0] a;
    logic              is_zero;
    assign a       = lk_addr[p*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (a == ADDR_W'(REG_ZERO));
    assign lk_busy[p] = busy[a] & ~(clr_en && (clr_addr == a)) & ~is_zero;
  end
endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-read-port MIPS register file with registered reads, optional write bypass,
// hardwired r0 and a pending-write scoreboard for hazard detection.
module mips_regfile_mp
  import mips_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rd_req,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     rd_valid,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ack,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs      [DEPTH];
  logic [DATA_W-1:0] rd_word   [NUM_RD];
  logic [DATA_W-1:0] rd_data_q [NUM_RD];
  logic [NUM_RD-1:0] lk_busy;
  logic [NUM_RD-1:0] rd_busy_q;
  logic              wr_zero;

  assign wr_zero = (ZERO_REG != 0) && (wr_addr == ADDR_W'(REG_ZERO));

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (rsv_en),
    .set_addr (rsv_addr),
    .clr_en   (wr_en),
    .clr_addr (wr_addr),
    .lk_addr  (rd_addr),
    .lk_busy  (lk_busy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_en && !wr_zero) begin
      regs[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[p*ADDR_W +: ADDR_W];
    always_comb begin
      rd_word[p] = regs[a];
      if (BYPASS != 0 && wr_en && wr_addr == a) rd_word[p] = wr_data;
      if (ZERO_REG != 0 && a == ADDR_W'(REG_ZERO)) rd_word[p] = '0;
    end
    assign rd_data[p*DATA_W +: DATA_W] = rd_data_q[p];
  end

  // rd_valid is a one-cycle pulse qualifying rd_data/rd_busy for the rd_req of the
  // previous cycle; there is no backpressure, and the data holds until the next rd_req.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_RD; p++) rd_data_q[p] <= '0;
      rd_busy_q <= '0;
      rd_valid  <= 1'b0;
      wr_ack    <= 1'b0;
    end else begin
      if (rd_req) begin
        for (int p = 0; p < NUM_RD; p++) rd_data_q[p] <= rd_word[p];
        rd_busy_q <= lk_busy;
      end
      rd_valid <= rd_req;
      wr_ack   <= wr_en;
    end
  end

  assign rd_busy = rd_busy_q;
endmodule

// File: tb/tb_mips_regfile_mp.sv
// Directed and random checks of the 2-port register file against a reference model.
module tb_mips_regfile_mp;
  import mips_pkg::*;

  localparam int W = 2 * DATA_W_DEF + 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_req;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        rd_valid;
  logic        wr_en;
  reg_addr_t   wr_addr;
  word_t       wr_data;
  logic        wr_ack;
  logic        rsv_en;
  reg_addr_t   rsv_addr;

  mips_regfile_mp dut (
    .clk      (clk),
    .reset    (reset),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .rd_valid (rd_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // reference model and scoreboard
  word_t          m_regs [32];
  logic [31:0]    m_busy;
  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   last_exp;
  int             checks = 0;
  int             errors = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic word_t exp_data(input reg_addr_t a, input logic we, input reg_addr_t wa,
                                     input word_t wd);
    if (a == REG_ZERO) return '0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input reg_addr_t a, input logic we, input reg_addr_t wa);
    if (a == REG_ZERO) return 1'b0;
    return m_busy[a] && !(we && wa == a);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_busy   = '0;
    last_exp = '0;
    exp_q.delete();
  endtask

  // driver: one clock of stimulus, then check the outputs it produced
  task automatic step(input logic rq, input reg_addr_t a0, input reg_addr_t a1,
                      input logic we, input reg_addr_t wa, input word_t wd,
                      input logic rs, input reg_addr_t ra);
    logic [W-1:0] e;
    rd_req   = rq;
    rd_addr  = {a1, a0};
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    rsv_en   = rs;
    rsv_addr = ra;
    if (rq) exp_q.push_back({exp_data(a1, we, wa, wd), exp_data(a0, we, wa, wd),
                             exp_busy(a1, we, wa), exp_busy(a0, we, wa)});
    @(posedge clk);
    #1;
    if (we && wa != REG_ZERO) m_regs[wa] = wd;
    if (we) m_busy[wa] = 1'b0;
    if (rs && ra != REG_ZERO) m_busy[ra] = 1'b1;
    rd_req = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
    chk("rd_valid", 96'(rd_valid), 96'(rq));
    chk("wr_ack", 96'(wr_ack), 96'(we));
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("rd_valid_spurious", 96'(1), 96'(0));
      else begin
        e = exp_q.pop_front();
        last_exp = e;
      end
    end
    exp_q.delete();
    chk("rd_data_busy", 96'({rd_data, rd_busy}), 96'(last_exp));
  endtask

  task automatic apply_reset(input logic rq);
    reset   = 1'b1;
    rd_req  = rq;
    rd_addr = {5'd5, 5'd3};
    wr_en   = 1'b0;
    rsv_en  = 1'b0;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    rd_req = 1'b0;
    model_clear();
    chk("rst_rd_valid", 96'(rd_valid), 96'(0));
    chk("rst_wr_ack", 96'(wr_ack), 96'(0));
    chk("rst_rd_data_busy", 96'({rd_data, rd_busy}), 96'(0));
  endtask

  initial begin
    reset = 1'b1; rd_req = 0; rd_addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
    rsv_en = 0; rsv_addr = '0;
    model_clear();
    @(posedge clk);
    apply_reset(1'b0);

    // write then read, r0 on the second port
    step(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
    step(1, 5, 0, 0, 0, 0, 0, 0);
    // same-cycle write and read: bypass
    step(1, 7, 7, 1, 7, 32'h12345678, 0, 0);
    // read hold while idle
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // r0 writes and reservations are ignored
    step(0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // scoreboard set/clear priority
    step(0, 0, 0, 0, 0, 0, 1, 3);
    step(1, 3, 5, 0, 0, 0, 0, 0);
    step(1, 3, 3, 1, 3, 32'h55, 0, 0);
    step(1, 3, 0, 1, 3, 32'h66, 1, 3);
    step(1, 3, 3, 0, 0, 0, 1, 3);
    step(1, 3, 4, 0, 0, 0, 0, 0);

    // fill r1..r31 back-to-back, then read every register
    for (int i = 1; i < 32; i++) step(0, 0, 0, 1, reg_addr_t'(i), 32'(i * 32'h01010101), 0, 0);
    for (int i = 0; i < 32; i++) step(1, reg_addr_t'(i), reg_addr_t'(31 - i), 0, 0, 0, 0, 0);

    // random mixed traffic
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), reg_addr_t'($urandom_range(0, 31)),
           reg_addr_t'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
           reg_addr_t'($urandom_range(0, 31)), word_t'($urandom),
           1'($urandom_range(0, 1)), reg_addr_t'($urandom_range(0, 31)));

    // reset during a read request drops it and clears all state
    step(0, 0, 0, 0, 0, 0, 1, 9);
    apply_reset(1'b1);
    for (int i = 0; i < 16; i++) step(1, reg_addr_t'(2 * i), reg_addr_t'(2 * i + 1), 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
